// File: rtl/nibble_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the nibble-serial adder: slice width, FSM state
// encoding and the two's-complement overflow helper.
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    // Overflow: operands agree in sign but the result sign differs.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// ---------------------------------------------------------------------------
// cla4_slice
// Purely combinational 4-bit carry-lookahead adder slice.
// Ports:
//   a[3:0], b[3:0] : addend nibbles
//   ci             : carry in
//   s[3:0]         : sum nibble
//   co             : carry out
// ---------------------------------------------------------------------------
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Carries fully expanded from c(i+1) = g_i | p_i & c_i so that no carry
    // depends on another computed carry.
    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

    assign s  = w_p ^ w_c[3:0];
    assign co = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
// Multi-cycle adder: adds two 4*NIBBLES-bit operands one nibble per clock
// through a single carry-lookahead slice, chaining the carry in a register.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : request, accepted only while ready=1
//   a_in, b_in, cin : operands and carry-in, sampled on accept
//   ready           : high in IDLE
//   done            : one-cycle pulse, result valid
//   sum, cout, ovf  : result, held from done until the next done
// ---------------------------------------------------------------------------
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a_in,
    input  logic [NIBBLE_W*NIBBLES-1:0] b_in,
    input  logic                      cin,
    output logic                      ready,
    output logic                      done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                      cout,
    output logic                      ovf
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    adder_state_t      r_state;
    adder_state_t      w_state_next;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_work;
    logic              r_carry;
    logic [IDX_W-1:0]  r_idx;

    logic              w_last;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_s_nib;
    logic              w_co;
    logic [W-1:0]      w_work_next;

    assign w_last  = (r_idx == LAST_IDX);
    assign w_a_nib = r_a[NIBBLE_W*r_idx +: NIBBLE_W];
    assign w_b_nib = r_b[NIBBLE_W*r_idx +: NIBBLE_W];

    cla4_slice u_slice (
        .a  (w_a_nib),
        .b  (w_b_nib),
        .ci (r_carry),
        .s  (w_s_nib),
        .co (w_co)
    );

    // Work register with the current nibble replaced; on the last nibble
    // this is the complete result, so the outputs load from it directly.
    always_comb begin
        w_work_next = r_work;
        w_work_next[NIBBLE_W*r_idx +: NIBBLE_W] = w_s_nib;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RUN;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, nibble iteration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_work  <= w_work_next;
                    r_carry <= w_co;
                    if (w_last) begin
                        sum  <= w_work_next;
                        cout <= w_co;
                        ovf  <= ovf_calc(r_a[W-1], r_b[W-1], w_work_next[W-1]);
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake outputs decode straight from the state register.
    assign ready = (r_state == IDLE);
    assign done  = (r_state == DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder
// Directed vectors with hand-computed results. The driver pushes expected
// results (value plus the cycle in which done must appear) into a queue; a
// monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin = 1'b0;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb_q[$];
    logic chk_ready_next = 1'b0;

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        if (chk_ready_next) begin
            chk("ready_after_done", {31'd0, ready}, 32'd1);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
            chk_ready_next = 1'b0;
        end else if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sum", {16'd0, sum}, {16'd0, e.s});
                chk("cout", {31'd0, cout}, {31'd0, e.co});
                chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
                chk("done_cycle", cyc, e.cyc);
                chk_ready_next = 1'b1;
            end
        end
    end

    // Wait for ready at a falling edge, bounded.
    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Wait until the scoreboard drains, bounded, then one extra cycle.
    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("done_timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    // Issue one request; expected done is five cycles after the accept cycle.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] es, input logic eco, input logic eov);
        exp_t e;
        wait_ready();
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        e.s = es; e.co = eco; e.ov = eov; e.cyc = cyc + 5;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   c0;

        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);

        // Basic add and carry ripple cases
        issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        drain();
        issue(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        drain();
        issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        drain();

        // Signed overflow; sum must hold the previous result during RUN
        issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            chk("sum_hold_run", {16'd0, sum}, 32'd0);
            chk("ready_low_run", {31'd0, ready}, 32'd0);
            @(negedge clk);
        end
        chk("sum_hold_run", {16'd0, sum}, 32'd0);
        drain();

        // Ignored start pulses in cycle 2 and cycle 5
        issue(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
        @(negedge clk);
        a_in = 16'hAAAA; b_in = 16'h5555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a_in = 16'hAAAA; b_in = 16'h5555; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a_in = '0; b_in = '0;
        drain();
        repeat (8) @(negedge clk);

        // start held high: done in cycles 5, 11, 17
        wait_ready();
        c0 = cyc;
        a_in = 16'h0001; b_in = 16'h0002; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e.s = 16'h0003; e.co = 1'b0; e.ov = 1'b0; e.cyc = c0 + 5 + 6 * k;
            sb_q.push_back(e);
        end
        repeat (17) @(negedge clk);
        start = 1'b0; a_in = '0; b_in = '0;
        drain();

        // Reset in cycle 3 of an operation
        wait_ready();
        a_in = 16'h1111; b_in = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_sum", {16'd0, sum}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        repeat (8) @(negedge clk);
        issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
